// File: rtl/sr_muldiv.sv
// Iterative RISC-V M-extension multiply/divide: one radix-2 step per cycle, WIDTH steps per operation.
// Divide-by-zero and signed overflow bypass the iteration; result holds in DONE until out_ready or kill.
module sr_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       oper,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam int W2 = 2 * WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       oper_q, oper_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] res_q, res_d;

   // Request decode: operand signedness, magnitudes and the bypass cases
   logic             is_div_in, a_signed, b_signed, a_neg, b_neg, neg_in;
   logic             div_zero, div_ovf, special_in;
   logic [WIDTH-1:0] a_mag, b_mag, special_res;

   always_comb begin
      is_div_in = oper[2];
      a_signed  = (oper == OP_MUL) || (oper == OP_MULH) || (oper == OP_MULHSU) ||
                  (oper == OP_DIV) || (oper == OP_REM);
      b_signed  = (oper == OP_MUL) || (oper == OP_MULH) ||
                  (oper == OP_DIV) || (oper == OP_REM);
      a_neg     = a_signed && srcA[WIDTH-1];
      b_neg     = b_signed && srcB[WIDTH-1];
      a_mag     = a_neg ? (~srcA + WIDTH'(1)) : srcA;
      b_mag     = b_neg ? (~srcB + WIDTH'(1)) : srcB;
      // Remainder takes the dividend's sign; everything else the product of signs
      neg_in    = (oper == OP_REM) ? a_neg : (a_neg ^ b_neg);
      div_zero  = is_div_in && (srcB == '0);
      div_ovf   = is_div_in && !oper[0] && (srcA == MOST_NEG) && (srcB == '1);
      special_in = div_zero || div_ovf;
      if (div_zero) begin
         special_res = oper[1] ? srcA : '1;
      end else begin
         special_res = oper[1] ? '0 : srcA;
      end
   end

   // One radix-2 step on the shared accumulator
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [W2-1:0]    mul_step, div_step, step;

   always_comb begin
      mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opb_q};
      mul_step  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
      div_shift = acc_q[W2-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opb_q};
      // Borrow out of the top bit means the trial subtraction is restored
      if (div_diff[WIDTH]) begin
         div_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
      step = oper_q[2] ? div_step : mul_step;
   end

   // Sign fix-up and final selection, applied to the last step's output
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix, fin;

   always_comb begin
      prod_fix = neg_q ? (~step + W2'(1)) : step;
      quo_fix  = neg_q ? (~step[WIDTH-1:0] + WIDTH'(1)) : step[WIDTH-1:0];
      rem_fix  = neg_q ? (~step[W2-1:WIDTH] + WIDTH'(1)) : step[W2-1:WIDTH];
      case (oper_q)
         OP_MUL:                        fin = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fin = prod_fix[W2-1:WIDTH];
         OP_DIV, 3'd5:                  fin = quo_fix;
         default:                       fin = rem_fix;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      oper_d  = oper_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               oper_d = oper;
               neg_d  = neg_in;
               if (special_in) begin
                  state_d = S_DONE;
                  res_d   = special_res;
               end else begin
                  state_d = S_CALC;
                  cnt_d   = CNT_W'(WIDTH);
                  opb_d   = is_div_in ? b_mag : a_mag;
                  acc_d   = {{WIDTH{1'b0}}, (is_div_in ? a_mag : b_mag)};
               end
            end
         end
         S_CALC: begin
            if (kill) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = step;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_DONE;
                  res_d   = fin;
               end
            end
         end
         S_DONE: begin
            if (kill || out_ready) begin
               state_d = S_IDLE;
               res_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            res_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         oper_q  <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         oper_q  <= oper_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = out_valid ? res_q : '0;

endmodule

// File: tb/tb_sr_muldiv.sv
// Scoreboard bench for sr_muldiv at WIDTH=32: reference results from native 64-bit arithmetic,
// queued at request time and compared when out_valid appears.
module tb_sr_muldiv;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, in_valid, kill, out_ready;
   logic         in_ready, out_valid;
   logic [2:0]   oper;
   logic [W-1:0] srcA, srcB, result;

   always #5 clk = ~clk;

   sr_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .oper(oper), .srcA(srcA), .srcB(srcB), .kill(kill),
      .out_valid(out_valid), .out_ready(out_ready), .result(result)
   );

   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      int              ia, ib;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      ia = a;
      ib = b;
      p  = '0;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return '1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return ia / ib;
         end
         3'd5: return (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Bypass cases raise out_valid on the accept edge itself; others after 32 step edges
   function automatic int lat_of(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (op[2] && b == 0) return 0;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return 32;
   endfunction

   // Called at a negedge; returns at the negedge after the accept edge with inputs scrambled
   task automatic drive_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit k, input bit push);
      in_valid = 1'b1;
      oper     = op;
      srcA     = a;
      srcB     = b;
      kill     = k;
      chk("in_ready_pre", in_ready, 1);
      if (push) exp_q.push_back(model(op, a, b));
      @(negedge clk);
      in_valid = 1'b0;
      kill     = 1'b0;
      oper     = 3'($urandom_range(0, 7));
      srcA     = $urandom;
      srcB     = $urandom;
      chk("busy", in_ready, 0);
   endtask

   task automatic collect(input string tag, input int exp_lat, input int hold);
      int           lat;
      logic [W-1:0] e;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_qsz"}, exp_q.size(), 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk({tag, "_res"}, result, e);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold_vld"}, out_valid, 1);
         chk({tag, "_hold_res"}, result, e);
         chk({tag, "_hold_rdy"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_idle_rdy"}, in_ready, 1);
      chk({tag, "_idle_vld"}, out_valid, 0);
      chk({tag, "_idle_res"}, result, 0);
   endtask

   logic [2:0]   t_op[12] = '{3'd1, 3'd0, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
   logic [W-1:0] t_a[12]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
   logic [W-1:0] t_b[12]  = '{32'd3, 32'd3, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [W-1:0] t_exp[12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;
      rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
      oper = '0; srcA = '0; srcB = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);

      // Requests, kill and out_ready during reset must all be ignored
      in_valid = 1'b1; kill = 1'b1; out_ready = 1'b1; oper = 3'd0; srcA = 32'd3; srcB = 32'd4;
      repeat (2) @(negedge clk);
      chk("rst_dom_rdy", in_ready, 1);
      chk("rst_dom_vld", out_valid, 0);
      in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
      rst = 1'b0;

      // Directed vectors; the first is accepted on the first edge after reset release
      for (int i = 0; i < 12; i++) begin
         chk("model_self", model(t_op[i], t_a[i], t_b[i]), t_exp[i]);
         drive_req(t_op[i], t_a[i], t_b[i], 1'b0, 1'b1);
         collect($sformatf("vec%0d", i), lat_of(t_op[i], t_a[i], t_b[i]), (i == 6) ? 5 : 0);
      end

      // kill in IDLE must not block a same-edge accept
      drive_req(3'd0, 32'd5, 32'd9, 1'b1, 1'b1);
      collect("kill_idle", 32, 0);

      // kill on the 10th CALC step
      drive_req(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
      for (int s = 1; s < 10; s++) begin
         @(negedge clk);
         chk("kill_no_out", out_valid, 0);
      end
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_rdy", in_ready, 1);
      chk("kill_vld", out_valid, 0);

      // reset on the 5th CALC step of the next operation
      drive_req(3'd5, 32'hDEAD_BEEF, 32'd3, 1'b0, 1'b0);
      for (int s = 1; s < 5; s++) begin
         @(negedge clk);
         chk("rst_no_out", out_valid, 0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_rdy", in_ready, 1);
      chk("midrst_vld", out_valid, 0);
      chk("midrst_res", result, 0);
      drive_req(3'd0, 32'd6, 32'd7, 1'b0, 1'b1);
      collect("mul_6x7", 32, 0);

      // kill together with out_ready in DONE discards the result
      drive_req(3'd5, 32'd77, 32'd0, 1'b0, 1'b0);
      chk("kd_vld_pre", out_valid, 1);
      kill = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      kill = 1'b0; out_ready = 1'b0;
      chk("kd_vld", out_valid, 0);
      chk("kd_rdy", in_ready, 1);
      chk("kd_res", result, 0);

      // Random operations against the reference model
      for (int i = 0; i < 16; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
         drive_req(rop, ra, rb, 1'b0, 1'b1);
         collect($sformatf("rnd%0d", i), lat_of(rop, ra, rb), 0);
      end

      chk("q_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sr_muldiv.md
SR_MULDIV -- requirements
Module: sr_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are even and at least 8.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, step-counter width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 oper  input  3  RISC-V M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 srcA  input  WIDTH  rs1 operand (multiplicand/dividend).
REQ-009 srcB  input  WIDTH  rs2 operand (multiplier/divisor).
REQ-010 kill  input  1  abort the in-flight operation.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 result  output  WIDTH  operation result.

Function
REQ-014 SHALL implement FSM with states IDLE, CALC, DONE.
REQ-015 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-016 Accept SHALL occur on an edge with in_valid & in_ready; at accept, oper/srcA/srcB SHALL be latched and never re-sampled.
REQ-017 Normal accept: IDLE->CALC, counter loaded with WIDTH; each CALC edge performs one radix-2 step and decrements the counter; on the edge where counter reaches 0, CALC->DONE.
REQ-018 Normal latency: out_valid SHALL rise exactly WIDTH cycles after the accept edge.
REQ-019 Multiply: shift-add on operand magnitudes with sign fix-up; MUL returns low WIDTH bits, MULH/MULHSU/MULHU return high WIDTH bits of the 2*WIDTH-bit product, treating operands signed/signed, signed/unsigned, unsigned/unsigned respectively.
REQ-020 Divide: restoring shift-subtract on magnitudes; DIV/REM signed with quotient truncated toward zero and remainder sign equal to dividend sign; DIVU/REMU unsigned.
REQ-021 Divisor zero: DIV/DIVU SHALL return all ones, REM/REMU SHALL return srcA; the path SHALL go IDLE->DONE directly (out_valid 1 cycle after accept).
REQ-022 Signed overflow (DIV/REM, srcA = most-negative, srcB = all ones): DIV SHALL return srcA, REM SHALL return 0; same 1-cycle IDLE->DONE path.
REQ-023 In DONE, result SHALL be stable while out_ready is 0; on edge with out_ready=1, DONE->IDLE.
REQ-024 No back-to-back: a new request SHALL be accepted no earlier than the edge after the DONE->IDLE transition.
REQ-025 kill=1 in CALC or DONE SHALL force IDLE on that edge with no output; kill in IDLE SHALL have no effect and SHALL NOT block a same-edge accept.
REQ-026 Simultaneous kill and out_ready in DONE: kill dominates; result is discarded.
REQ-027 result SHALL be 0 whenever out_valid is 0.
REQ-028 All internal arithmetic SHALL use WIDTH-bit or 2*WIDTH-bit registers; no truncation other than the final result selection of REQ-019/020.

Reset
REQ-029 rst=1 on a rising edge SHALL force IDLE, counter 0, result 0, out_valid 0, in_ready 1, from any state including mid-CALC.
REQ-030 rst SHALL dominate in_valid, kill and out_ready on the same edge; no request is accepted while rst=1.
REQ-031 After rst deasserts, first accept SHALL be possible on the next edge.

Verification (WIDTH=32)
REQ-032 MULH srcA=0xFFFFFFFE, srcB=3 -> result 0xFFFFFFFF, out_valid exactly 32 cycles after accept; MUL same operands -> 0xFFFFFFFA.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU srcA=0xFFFFFFFF, srcB=2 -> 0xFFFFFFFF.
REQ-034 DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-035 DIVU srcA=0x1234, srcB=0 -> 0xFFFFFFFF after 1 cycle; REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-036 out_ready held 0 for 5 cycles in DONE -> result and out_valid stable, in_ready 0; out_ready=1 -> IDLE next edge, in_ready 1.
REQ-037 kill at CALC step 10, then rst at CALC step 5 of a second operation -> both return to IDLE, out_valid never asserted, following MUL 6 x 7 -> 42 with 32-cycle latency.
